vr_vc_converter: RTL and testbench

- Upstream partner of the valid/credit to valid/ready converter.
- Accepts beats on a valid/ready slave interface and forwards them on a valid/credit master link.
- Sends a beat only when it holds at least one credit; it regains credits from credit pulses returned by the receiver.
- Registered output stage: each accepted beat appears on the link exactly one cycle later.

---
 rtl/vr_vc_converter.sv | 96 +++++++++
 tb/tb_vr_vc_converter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vr_vc_converter.sv
`default_nettype none
// ============================================================================
// Module   : vr_vc_converter
// Brief    : Valid/ready slave to valid/credit master converter. Beats are
//            accepted only while at least one credit is held and appear on the
//            link through a single output register (one cycle of latency).
//            Optional build macro VR_VC_CREDIT_ERR_EN adds a sticky err_o flag
//            raised on a credit overflow.
// Revision : 1.0 - initial release
// ============================================================================
module vr_vc_converter #(
    parameter int DATA_WIDTH = 8,
    parameter int CREDIT_NUM = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           s_data_i,
    input  logic                            s_valid_i,
    output logic                            s_ready_o,
    output logic [DATA_WIDTH-1:0]           m_data_o,
    output logic                            m_valid_o,
    input  logic                            m_credit_i,
    output logic [$clog2(CREDIT_NUM+1)-1:0] credit_cnt_o
`ifdef VR_VC_CREDIT_ERR_EN
    ,
    output logic                            err_o
`endif
);

    localparam int                 c_CNT_W   = $clog2(CREDIT_NUM + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CREDIT_NUM);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_ready;
    logic                  w_acc;
    logic                  w_overflow;

    // Ready depends only on the registered count, never on the same-cycle
    // credit input, so a credit arriving at zero is usable one cycle later.
    assign w_ready    = (r_cnt != '0);
    assign w_acc      = s_valid_i && w_ready;
    // A credit with nothing to consume it while already full would exceed the
    // receiver's buffer depth; the counter saturates instead of wrapping.
    assign w_overflow = m_credit_i && !w_acc && (r_cnt == c_CNT_MAX);

    // Next credit count: a send and a return in the same cycle cancel out.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_acc && !m_credit_i) begin
            w_cnt_nxt = r_cnt - c_CNT_ONE;
        end else if (!w_acc && m_credit_i && !w_overflow) begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
    end

    // Credit counter and output register; reset drops any beat in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_acc;
            if (w_acc) begin
                r_data <= s_data_i;
            end
        end
    end

`ifdef VR_VC_CREDIT_ERR_EN
    logic r_err;

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_overflow) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`endif

    assign s_ready_o    = w_ready;
    assign m_valid_o    = r_valid;
    assign m_data_o     = r_data;
    assign credit_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vr_vc_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vr_vc_converter
// Brief    : Scoreboard bench for vr_vc_converter. A driver task applies one
//            cycle of stimulus, predicts acceptance from a credit-count model
//            and pushes expected link beats; an independent monitor pops and
//            compares every m_valid_o beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vr_vc_converter;

    localparam int DATA_WIDTH = 8;
    localparam int CREDIT_NUM = 2;
    localparam int CNT_W      = $clog2(CREDIT_NUM + 1);
    localparam int RET_LAT    = 3;

    logic                  clk;
    logic                  rst;
    logic [DATA_WIDTH-1:0] s_data_i;
    logic                  s_valid_i;
    logic                  s_ready_o;
    logic [DATA_WIDTH-1:0] m_data_o;
    logic                  m_valid_o;
    logic                  m_credit_i;
    logic [CNT_W-1:0]      credit_cnt_o;
`ifdef VR_VC_CREDIT_ERR_EN
    logic                  err_o;
`endif

    vr_vc_converter #(
        .DATA_WIDTH (DATA_WIDTH),
        .CREDIT_NUM (CREDIT_NUM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data_i     (s_data_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .m_data_o     (m_data_o),
        .m_valid_o    (m_valid_o),
        .m_credit_i   (m_credit_i),
        .credit_cnt_o (credit_cnt_o)
`ifdef VR_VC_CREDIT_ERR_EN
        ,
        .err_o        (err_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        int                    due;
    } exp_t;

    exp_t sb_q[$];
    int   ret_q[$];
    int   cyc;
    int   n_checks;
    int   n_err;
    int   m_cnt;
    bit   m_err;
    bit   recv_en;
    int   seen_55;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every link beat must match the oldest expected beat and arrive
    // exactly one cycle after its acceptance.
    always @(negedge clk) begin
        if (m_valid_o === 1'b1) begin
            if (m_data_o === 8'h55) seen_55++;
            if (sb_q.size() == 0) begin
                chk("unexpected_beat", {24'd0, m_data_o}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("beat_data", {24'd0, m_data_o}, {24'd0, e.data});
                chk("beat_time", cyc, e.due);
            end
        end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("missing_beat", {24'd0, 8'h00}, {24'd0, e.data});
        end
    end

    // One clock of stimulus. Checks the status outputs against the model,
    // predicts acceptance, then advances the model across the edge.
    task automatic step(input logic v, input logic [DATA_WIDTH-1:0] d,
                        input logic c_in, input logic r, output bit acc);
        logic c;
        c = c_in;
        if (recv_en && ret_q.size() != 0 && ret_q[0] == cyc) begin
            void'(ret_q.pop_front());
            c = 1'b1;
        end
        s_valid_i  = v;
        s_data_i   = d;
        m_credit_i = c;
        rst        = r;
        chk("credit_cnt", {{(32-CNT_W){1'b0}}, credit_cnt_o}, m_cnt);
        chk("s_ready", {31'd0, s_ready_o}, {31'd0, (m_cnt != 0)});
`ifdef VR_VC_CREDIT_ERR_EN
        chk("err_o", {31'd0, err_o}, {31'd0, m_err});
`endif
        acc = v && (m_cnt != 0);
        if (r) begin
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            if (acc) begin
                sb_q.push_back('{data: d, due: cyc + 1});
                if (recv_en) ret_q.push_back(cyc + RET_LAT);
            end
            m_cnt = m_cnt - int'(acc) + int'(c);
            if (m_cnt > CREDIT_NUM) begin
                m_cnt = CREDIT_NUM;
                m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            sb_q.delete();
            ret_q.delete();
        end
    endtask

    initial begin
        bit acc;
        bit v;
        logic [DATA_WIDTH-1:0] d;
        int idx;
        n_checks   = 0;
        n_err      = 0;
        m_cnt      = 0;
        m_err      = 1'b0;
        recv_en    = 1'b0;
        seen_55    = 0;
        rst        = 1'b1;
        s_valid_i  = 1'b0;
        s_data_i   = '0;
        m_credit_i = 1'b0;
        @(posedge clk);
        #1;

        // Reset / init: two reset cycles, then two credit grants.
        step(1'b0, 8'h00, 1'b0, 1'b1, acc);
        step(1'b0, 8'h00, 1'b0, 1'b1, acc);
        chk("rst_m_valid", {31'd0, m_valid_o}, 32'd0);
        chk("rst_m_data", {24'd0, m_data_o}, 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);

        // Basic transfer: two beats drain the credits, third is held off.
        step(1'b1, 8'hA5, 1'b0, 1'b0, acc);
        step(1'b1, 8'h3C, 1'b0, 1'b0, acc);
        step(1'b1, 8'h77, 1'b0, 1'b0, acc);
        chk("held_0x77", {31'd0, acc}, 32'd0);

        // Credit return unblocks the pending beat one cycle later.
        step(1'b1, 8'h77, 1'b1, 1'b0, acc);
        chk("no_same_cycle_use", {31'd0, acc}, 32'd0);
        step(1'b1, 8'h77, 1'b0, 1'b0, acc);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);

        // Simultaneous credit and send at cnt=1 keeps the count.
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        step(1'b1, 8'h99, 1'b1, 1'b0, acc);
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);

        // Stream 0x00..0x13 against a receiver returning credits 3 cycles later.
        recv_en = 1'b1;
        idx = 0;
        v = 1'b0;
        for (int k = 0; k < 400 && idx < 20; k++) begin
            if (!v) v = ($urandom_range(0, 3) != 0);
            step(v, DATA_WIDTH'(idx), 1'b0, 1'b0, acc);
            if (acc) begin
                idx++;
                v = 1'b0;
            end
        end
        chk("stream_done", idx, 20);
        for (int k = 0; k < 8; k++) step(1'b0, 8'h00, 1'b0, 1'b0, acc);

        // Overflow at full count saturates (and sets err_o when built in).
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b0, 1'b0, acc);

        // Reset while a beat is being accepted: it must never reach the link.
        step(1'b1, 8'h55, 1'b0, 1'b1, acc);
        chk("rst_drop_valid", {31'd0, m_valid_o}, 32'd0);
        for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("0x55_never_seen", seen_55, 0);

        // Randomized traffic with the delayed-credit receiver.
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        v = 1'b0;
        d = '0;
        for (int k = 0; k < 300; k++) begin
            if (!v) begin
                v = ($urandom_range(0, 2) != 0);
                d = DATA_WIDTH'($urandom);
            end
            step(v, d, 1'b0, 1'b0, acc);
            if (acc) v = 1'b0;
        end
        for (int k = 0; k < 8; k++) step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
